adaptive_sample_capture: RTL
============================

// Module: adaptive_sample_capture
// PURPOSE
// - Parametrised successor to the single-register sampler: captures a run-time-selected number of
//   DATA_W-bit ADC words into an on-chip DEPTH-entry RAM, with programmable decimation.
// - Sits between the ADC front-end and the readout/host logic of the AdaptiveSampling path.
// - Capture is launched by a start pulse and reports a sticky done; the buffer is read back
//   through a synchronous read port.
// PARAMETERS
// - DATA_W  14    width of one ADC sample
// - DEPTH   1024  buffer entries; power of two, >= 2
// - ADDR_W  $clog2(DEPTH)  address width (derived; do not override)
// - DEC_W   8     width of the decimation-factor input
// PORTS
// - clk           in   1         system clock; all logic on rising edge
// - reset         in   1         asynchronous, active-low reset
// - start         in   1         1-cycle pulse: arm a new capture
// - sample_target in   ADDR_W+1  samples to store, 0..DEPTH; values > DEPTH are clamped to DEPTH
// - decim         in   DEC_W     keep 1 of (decim+1) valid inputs; 0 = keep every sample
// - data_valid    in   1         data_in is a fresh sample this cycle
// - data_in       in   DATA_W    ADC sample
// - rd_addr       in   ADDR_W    readout address
// - rd_data       out  DATA_W    RAM[rd_addr], registered, 1-cycle latency
// - busy          out  1         capture in progress
// - done          out  1         sticky: capture complete
// - sample_count  out  ADDR_W+1  samples stored so far in the current/last capture
// BEHAVIOUR
// - Reset: state=IDLE, busy=0, done=0, sample_count=0, decimation counter=0, rd_data=0.
//   RAM contents are not cleared. Reset mid-capture aborts; no further writes occur.
// - FSM: IDLE -> CAPTURE on start. CAPTURE -> DONE when sample_count reaches the latched target.
//   DONE -> CAPTURE on start.
// - On start: latch clamp(sample_target) and decim, clear sample_count, decimation counter and
//   done, set busy the next cycle.
// - If the latched target is 0, go directly to DONE (done=1 next cycle, busy stays 0).
// - Start while in CAPTURE restarts: counters clear, new target/decim latched, writes resume at
//   address 0. Start in the same cycle as the final write: the write completes, then the restart
//   wins (state CAPTURE, done=0).
// - In CAPTURE, on each data_valid cycle:
//   - If the decimation counter == 0: write data_in to RAM[sample_count] and increment
//     sample_count.
//   - Otherwise, no write.
//   - The decimation counter increments and wraps from decim back to 0.
//   - data_valid=0 cycles do not advance anything.
// - Completion: the cycle after the write that makes sample_count == target, done=1 and busy=0.
//   done holds until start or reset. No writes occur in IDLE or DONE.
// - The first accepted sample after start is the first data_valid cycle at least 1 cycle after
//   the start pulse; data_valid coinciding with start is ignored.
// - Read port is always active. rd_data reflects RAM[rd_addr] sampled on the previous edge.
//   Read and write to the same address in the same cycle returns the OLD data.
// - Width rules:
//   - sample_count is ADDR_W+1 bits so it can represent DEPTH.
//   - Write address = sample_count[ADDR_W-1:0].
//   - The decimation counter is DEC_W bits and never exceeds decim.
// STRUCTURE
// - sampler_pkg.vh:
//   - state encodings ST_IDLE=2'd0, ST_CAPTURE=2'd1, ST_DONE=2'd2
//   - default DATA_W/DEPTH constants shared with the rest of AdaptiveSampling
// - Sub-module sample_ram: simple dual-port RAM
//   - (we, waddr, wdata, raddr, rdata), registered read, old-data on collision
//   - Parameters DATA_W, DEPTH.
// - Top: FSM, target/decim latches, decimation counter, sample counter, status outputs.
// TESTING
// 1. Reset then start, target=8, decim=0, data_valid=1, data_in=100..107:
//    done=1 exactly 1 cycle after the 8th write; RAM[0..7]=100..107; sample_count=8.
// 2. target=4, decim=2, continuous data_in=0..11:
//    RAM[0..3]=0,3,6,9; done after the input 9 is written; data_valid gaps do not shift the
//    phase.
// 3. target=0 -> done=1 next cycle, busy never 1, no RAM change.
//    target=2000 with DEPTH=1024 -> clamps, 1024 writes, sample_count=1024.
// 4. Start again mid-capture at sample_count=5, target=3:
//    writes restart at addr 0, done after 3 samples.
//    Assert reset at sample_count=5 -> busy=0, done=0, sample_count=0 immediately,
//    with no further writes.
// 5. Readout: after scenario 1, rd_addr=3 -> rd_data=103 one cycle later.
//    Same-cycle write/read of addr 0 returns old data.
// 6. data_valid asserted in the same cycle as start -> that sample is not stored;
//    RAM[0] holds the next valid sample.

Source files
------------

// File: rtl/adaptive_sample_capture_pkg.sv
// Shared definitions for the AdaptiveSampling capture path:
// capture FSM encodings and the default sample/buffer geometry.
package adaptive_sample_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam int DEF_DATA_W = 14;
  localparam int DEF_DEPTH  = 1024;
  localparam int DEF_DEC_W  = 8;

endpackage

// File: rtl/adaptive_sample_capture_sample_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// A same-address read and write in one cycle returns the previously stored word.
module sample_ram
  import adaptive_sample_capture_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Read register; sees the array before this edge's write lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/adaptive_sample_capture.sv
// Start-triggered, decimating capture of ADC words into an on-chip buffer,
// with sticky completion status and a free-running synchronous readout port.
module adaptive_sample_capture
  import adaptive_sample_capture_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DEC_W  = DEF_DEC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   sample_target,
  input  logic [DEC_W-1:0]  decim,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sample_count
);

  localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]  CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [DEC_W-1:0] DEC_ONE = {{(DEC_W-1){1'b0}}, 1'b1};

  state_e            r_state;
  state_e            w_state_nxt;
  state_e            w_start_state;
  logic [ADDR_W:0]   r_target;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   w_target_clamped;
  logic [ADDR_W:0]   w_count_inc;
  logic [DEC_W-1:0]  r_decim;
  logic [DEC_W-1:0]  r_dec_cnt;
  logic              r_busy;
  logic              r_done;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_capturing;
  logic              w_we;
  logic              w_last_write;

  assign w_target_clamped = (sample_target > DEPTH_C) ? DEPTH_C : sample_target;
  assign w_start_state    = (w_target_clamped == '0) ? ST_DONE : ST_CAPTURE;
  assign w_capturing      = (r_state == ST_CAPTURE) && data_valid;
  assign w_we             = w_capturing && (r_dec_cnt == '0);
  assign w_count_inc      = r_count + CNT_ONE;
  assign w_last_write     = w_we && (w_count_inc == r_target);

  // State register with registered status flags derived from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic; a start pulse overrides completion in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = w_start_state;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (start) begin
          w_state_nxt = w_start_state;
        end else if (w_last_write) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_CAPTURE;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_state_nxt = w_start_state;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Status decode of the upcoming state.
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    if (w_state_nxt == ST_CAPTURE) begin
      w_busy_nxt = 1'b1;
    end else if (w_state_nxt == ST_DONE) begin
      w_done_nxt = 1'b1;
    end else begin
      w_busy_nxt = 1'b0;
      w_done_nxt = 1'b0;
    end
  end

  // Capture parameters plus sample and decimation counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_target  <= '0;
      r_decim   <= '0;
      r_count   <= '0;
      r_dec_cnt <= '0;
    end else if (start) begin
      r_target  <= w_target_clamped;
      r_decim   <= decim;
      r_count   <= '0;
      r_dec_cnt <= '0;
    end else if (w_capturing) begin
      if (r_dec_cnt == r_decim) begin
        r_dec_cnt <= '0;
      end else begin
        r_dec_cnt <= r_dec_cnt + DEC_ONE;
      end
      if (w_we) begin
        r_count <= w_count_inc;
      end
    end
  end

  sample_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (w_we),
    .waddr (r_count[ADDR_W-1:0]),
    .wdata (data_in),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign busy         = r_busy;
  assign done         = r_done;
  assign sample_count = r_count;

endmodule
